// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU and its program loader.
// State encoding, default widths and fill word.
package cpu_pkg;

  localparam int CPU_ADDR_W = 3;
  localparam int CPU_DEPTH  = 8;
  localparam int CPU_DATA_W = 11;

  localparam logic [CPU_DATA_W-1:0] CPU_FILL_WORD = 11'h000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FILL = 3'd2,
    ST_DONE = 3'd3,
    ST_HALT = 3'd4,
    ST_RUN  = 3'd5,
    ST_STEP = 3'd6
  } state_t;

endpackage

// File: rtl/program_loader_exec_gate.sv
// Execution gate: HALT/RUN/STEP control of the CPU PC enable.
// Inactive (ST_IDLE) until a load completes; load_abort wins.
module exec_gate
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   load_abort,
  input  logic   run_req,
  input  logic   step_req,
  output logic   pc_enable,
  output state_t gate_state
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      gate_state <= ST_IDLE;
      pc_enable  <= 1'b0;
    end else if (load_abort) begin
      gate_state <= ST_IDLE;
      pc_enable  <= 1'b0;
    end else begin
      unique case (gate_state)
        ST_IDLE: begin
          pc_enable <= 1'b0;
          if (start) gate_state <= ST_HALT;
        end
        ST_HALT: begin
          if (run_req) begin
            gate_state <= ST_RUN;
            pc_enable  <= 1'b1;
          end else if (step_req) begin
            gate_state <= ST_STEP;
            pc_enable  <= 1'b1;
          end else begin
            pc_enable  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!run_req) begin
            gate_state <= ST_HALT;
            pc_enable  <= 1'b0;
          end
        end
        ST_STEP: begin
          // a step always returns to HALT, spacing enables by 2
          gate_state <= ST_HALT;
          pc_enable  <= 1'b0;
        end
        default: begin
          gate_state <= ST_IDLE;
          pc_enable  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: streams instruction words into CPU RAM,
// fills unused rows, then gates execution via exec_gate.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = CPU_DEPTH,
  parameter int DATA_W = CPU_DATA_W,
  parameter logic [DATA_W-1:0] FILL_WORD = CPU_FILL_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              run_req,
  input  logic              step_req,
  output logic [DATA_W-1:0] RAM_Write_Data,
  output logic [ADDR_W-1:0] RAM_Write_Address,
  output logic              RAM_Write_Enable,
  output logic              PC_Enable,
  output logic              cpu_clear,
  output logic              loaded,
  output logic              busy,
  output logic [2:0]        state
);

  localparam int LW = ADDR_W + 1;

  state_t            st_q;
  state_t            gate_st;
  logic [ADDR_W-1:0] addr_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     len_sat;
  logic [LW-1:0]     cnt_nx;
  logic              loading;
  logic              load_abort;

  assign len_sat = (load_len > LW'(DEPTH)) ? LW'(DEPTH) : load_len;
  assign cnt_nx  = {1'b0, addr_q} + LW'(1);
  assign loading = (st_q == ST_LOAD) || (st_q == ST_FILL);
  assign load_abort = load_start && !loading;

  // ST_HALT in st_q means "executing"; exec_gate owns the detail
  assign state = (st_q == ST_HALT) ? gate_st : st_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q              <= ST_IDLE;
      addr_q            <= '0;
      len_q             <= '0;
      in_ready          <= 1'b0;
      RAM_Write_Data    <= '0;
      RAM_Write_Address <= '0;
      RAM_Write_Enable  <= 1'b0;
      cpu_clear         <= 1'b0;
      loaded            <= 1'b0;
      busy              <= 1'b0;
    end else begin
      RAM_Write_Enable <= 1'b0;
      cpu_clear        <= 1'b0;
      if (load_abort) begin
        len_q  <= len_sat;
        addr_q <= '0;
        loaded <= 1'b0;
        busy   <= 1'b1;
        if (len_sat == '0) begin
          st_q     <= ST_FILL;
          in_ready <= 1'b0;
        end else begin
          st_q     <= ST_LOAD;
          in_ready <= 1'b1;
        end
      end else begin
        unique case (st_q)
          ST_LOAD: begin
            if (in_valid && in_ready) begin
              RAM_Write_Enable  <= 1'b1;
              RAM_Write_Address <= addr_q;
              RAM_Write_Data    <= in_data;
              if (cnt_nx == len_q) begin
                in_ready <= 1'b0;
                if (len_q < LW'(DEPTH)) begin
                  st_q   <= ST_FILL;
                  addr_q <= addr_q + 1'b1;
                end else begin
                  st_q      <= ST_DONE;
                  busy      <= 1'b0;
                  cpu_clear <= 1'b1;
                  loaded    <= 1'b1;
                end
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
          end
          ST_FILL: begin
            RAM_Write_Enable  <= 1'b1;
            RAM_Write_Address <= addr_q;
            RAM_Write_Data    <= FILL_WORD;
            if (addr_q == ADDR_W'(DEPTH - 1)) begin
              st_q      <= ST_DONE;
              busy      <= 1'b0;
              cpu_clear <= 1'b1;
              loaded    <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          ST_DONE: st_q <= ST_HALT;
          default: ;
        endcase
      end
    end
  end

  exec_gate u_exec_gate (
    .clk        (clk),
    .reset      (reset),
    .start      (st_q == ST_DONE),
    .load_abort (load_abort),
    .run_req    (run_req),
    .step_req   (step_req),
    .pc_enable  (PC_Enable),
    .gate_state (gate_st)
  );

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads,
// randomized run/step against a reference model, corner sequences.
module tb_program_loader;
  import cpu_pkg::*;

  localparam int AW = 3;
  localparam int D  = 8;
  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          run_req = 1'b0;
  logic          step_req = 1'b0;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          pc_en;
  logic          cpu_clear;
  logic          loaded;
  logic          busy;
  logic [2:0]    state;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk               (clk),
    .reset             (reset),
    .load_start        (load_start),
    .load_len          (load_len),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .run_req           (run_req),
    .step_req          (step_req),
    .RAM_Write_Data    (wr_data),
    .RAM_Write_Address (wr_addr),
    .RAM_Write_Enable  (wr_en),
    .PC_Enable         (pc_en),
    .cpu_clear         (cpu_clear),
    .loaded            (loaded),
    .busy              (busy),
    .state             (state)
  );

  typedef struct {
    int len;
    int vmode;
    int base;
    int exp_len;
  } lv_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_load(input lv_t v);
    logic [DW-1:0] exp_data [D];
    int  sent, nwr, nclr;
    bit  pend;
    for (int i = 0; i < D; i++)
      exp_data[i] = (i < v.exp_len) ? DW'(v.base + i) : CPU_FILL_WORD;
    load_len   = (AW+1)'(v.len);
    load_start = 1'b1;
    in_valid   = 1'b0;
    cyc();
    load_start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_loaded", loaded, 0);
    chk("start_pc", pc_en, 0);
    chk("start_in_ready", in_ready, v.exp_len > 0);
    chk("start_state", state, v.exp_len > 0 ? 1 : 2);
    sent = 0; nwr = 0; nclr = 0;
    for (int c = 0; c < 200 && nclr == 0; c++) begin
      case (v.vmode)
        0: in_valid = (sent < v.exp_len);
        1: in_valid = (sent < v.exp_len) && (c % 2 == 0);
        default: in_valid = (sent < v.exp_len) && ($urandom % 2 == 1);
      endcase
      in_data = DW'(v.base + sent);
      pend = in_valid && in_ready;
      if (pend) sent++;
      cyc();
      if (pend) chk("xfer_latency", wr_en, 1);
      if (pend && sent == v.exp_len) chk("in_ready_drop", in_ready, 0);
      if (wr_en) begin
        if (nwr < D) begin
          chk("wr_addr", wr_addr, nwr);
          chk("wr_data", wr_data, exp_data[nwr]);
        end
        nwr++;
      end
      chk("wr_pc_overlap", wr_en & pc_en, 0);
      if (cpu_clear) nclr++;
    end
    in_valid = 1'b0;
    chk("done_timeout", nclr, 1);
    chk("write_count", nwr, D);
    chk("xfer_count", sent, v.exp_len);
    chk("done_state", state, 3);
    chk("done_loaded", loaded, 1);
    cyc();
    chk("halt_state", state, 4);
    chk("halt_clear", cpu_clear, 0);
    chk("halt_wr_en", wr_en, 0);
    chk("halt_busy", busy, 0);
    chk("halt_loaded", loaded, 1);
    chk("halt_pc", pc_en, 0);
  endtask

  // Reference: HALT waits; run wins over step; RUN lasts while
  // run_req is high; STEP lasts exactly one cycle.
  task automatic rand_exec(input int n);
    string mode = "halt";
    for (int i = 0; i < n; i++) begin
      if ($urandom % 4 == 0) run_req = ~run_req;
      step_req = ($urandom % 3 == 0);
      if (mode == "run") mode = run_req ? "run" : "halt";
      else if (mode == "step") mode = "halt";
      else if (run_req) mode = "run";
      else if (step_req) mode = "step";
      else mode = "halt";
      cyc();
      chk("rand_pc", pc_en, mode != "halt");
      chk("rand_state", state,
          mode == "halt" ? 4 : (mode == "run" ? 5 : 6));
      chk("rand_wr_en", wr_en, 0);
    end
    run_req = 1'b0;
    step_req = 1'b0;
    cyc();
    cyc();
    chk("rand_end_state", state, 4);
  endtask

  lv_t vecs [5];
  int  nclr, nwr;

  initial begin
    vecs[0] = '{len: 8,  vmode: 0, base: 'h101, exp_len: 8};
    vecs[1] = '{len: 3,  vmode: 1, base: 'h200, exp_len: 3};
    vecs[2] = '{len: 12, vmode: 2, base: 'h300, exp_len: 8};
    vecs[3] = '{len: 0,  vmode: 0, base: 'h000, exp_len: 0};
    vecs[4] = '{len: 5,  vmode: 2, base: 'h040, exp_len: 5};

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      load_start = 1'($urandom);
      load_len   = (AW+1)'($urandom);
      in_valid   = 1'($urandom);
      in_data    = DW'($urandom);
      run_req    = 1'($urandom);
      step_req   = 1'($urandom);
      cyc();
    end
    chk("rst_state", state, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pc", pc_en, 0);
    chk("rst_clear", cpu_clear, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_busy", busy, 0);
    load_start = 0; in_valid = 0;
    run_req = 1; step_req = 1;
    reset = 1'b1;
    cyc();
    step_req = 0;
    cyc();
    chk("idle_state", state, 0);
    chk("idle_pc", pc_en, 0);
    run_req = 0;

    for (int k = 0; k < 5; k++) begin
      do_load(vecs[k]);
      rand_exec(30);
    end

    // single step
    step_req = 1; cyc(); step_req = 0;
    chk("step_pc1", pc_en, 1);
    chk("step_state", state, 6);
    cyc(); chk("step_pc2", pc_en, 0);
    cyc(); chk("step_pc3", pc_en, 0);

    // held step request: one enable per two cycles
    step_req = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("step_b2b", pc_en, (i % 2 == 0));
    end
    step_req = 0;
    cyc();

    // run for 5 cycles
    run_req = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("run_pc", pc_en, 1);
    end
    run_req = 0;
    cyc();
    chk("run_stop_pc", pc_en, 0);
    chk("run_stop_state", state, 4);

    // abort from RUN
    run_req = 1; cyc();
    chk("abort_pre_pc", pc_en, 1);
    load_len = 1; load_start = 1; cyc();
    load_start = 0; run_req = 0;
    chk("abort_pc", pc_en, 0);
    chk("abort_loaded", loaded, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_state", state, 1);
    load_len = 0; load_start = 1; cyc();
    load_start = 0;
    chk("ignore_state", state, 1);
    chk("ignore_in_ready", in_ready, 1);
    in_valid = 1; in_data = 11'h7AB; cyc();
    in_valid = 0;
    chk("abort_wr_en", wr_en, 1);
    chk("abort_wr_addr", wr_addr, 0);
    chk("abort_wr_data", wr_data, 'h7AB);
    chk("abort_fill_state", state, 2);
    nclr = 0; nwr = 0;
    for (int c = 0; c < 20 && nclr == 0; c++) begin
      cyc();
      if (wr_en) begin
        chk("abort_fill_addr", wr_addr, nwr + 1);
        chk("abort_fill_data", wr_data, CPU_FILL_WORD);
        nwr++;
      end
      if (cpu_clear) nclr++;
    end
    chk("abort_done", nclr, 1);
    chk("abort_fill_cnt", nwr, D - 1);
    cyc();
    chk("abort_halt", state, 4);

    // reset in the middle of FILL
    load_len = 0; load_start = 1; cyc();
    load_start = 0;
    cyc(); cyc();
    chk("mid_fill_state", state, 2);
    reset = 0; cyc();
    chk("mid_rst_state", state, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_loaded", loaded, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1; cyc();
    chk("mid_rst_idle", state, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Front-end stage that sits directly upstream of the 4-bit CPU.
- Accepts a program as a stream of 11-bit instruction words over a valid/ready handshake and writes them into CPU RAM through the CPU's RAM write port (RAM_Write_Data/Address/Enable). Unused rows are filled with a fixed word.
- Afterwards it gates CPU execution through PC_Enable in free-run or single-step mode.
- One instance per CPU.

Parameters:
- ADDR_W, 3, RAM address width.
- DEPTH, 8, number of RAM rows (2**ADDR_W).
- DATA_W, 11, instruction word width.
- FILL_WORD, 11'h000, word written to rows not covered by the loaded program.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset.
- load_start  input  1  one-cycle pulse; begins a new load.
- load_len  input  ADDR_W+1  number of words to load; sampled on load_start.
- in_data  input  DATA_W  instruction word from host.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- run_req  input  1  level; free-run the CPU while high.
- step_req  input  1  one-cycle pulse; execute one instruction.
- RAM_Write_Data  output  DATA_W  to CPU RAM write data.
- RAM_Write_Address  output  ADDR_W  to CPU RAM write address.
- RAM_Write_Enable  output  1  to CPU RAM write enable.
- PC_Enable  output  1  to CPU clock-gate enable.
- cpu_clear  output  1  one-cycle pulse after a load completes; host/CPU reset request.
- loaded  output  1  valid program present in RAM.
- busy  output  1  high in LOAD or FILL.
- state  output  3  current FSM state encoding.

Behaviour:
- Reset: when reset==0 at a rising clk edge, the block enters IDLE. All outputs reset to 0: in_ready, RAM_Write_*, PC_Enable, cpu_clear, loaded, busy. Internal address counter resets to 0.
- All outputs are registered and change only on the clk rising edge. PC_Enable must never glitch.
- FSM states: IDLE=0, LOAD=1, FILL=2, DONE=3, HALT=4, RUN=5, STEP=6.
- IDLE:
  - load_start -> LOAD; addr counter=0.
  - len = min(load_len, DEPTH), saturating.
  - If len==0, go to FILL instead of LOAD.
  - run_req and step_req are ignored in IDLE.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready.
  - Cycle after a transfer: RAM_Write_Enable=1, RAM_Write_Address=addr, RAM_Write_Data=word. Latency is 1 cycle. The counter then increments.
  - When the transfer count reaches len: go to FILL if len<DEPTH, else DONE. in_ready drops in the same cycle the last word is accepted.
  - No transfer while in_valid=0; the state is held indefinitely.
- FILL:
  - in_ready=0.
  - Writes FILL_WORD to one address per cycle, from len up to DEPTH-1, then goes to DONE.
- DONE:
  - One cycle: cpu_clear=1 and loaded set to 1, then HALT.
  - No RAM write is issued in DONE.
- HALT:
  - PC_Enable=0.
  - run_req=1 -> RUN.
  - Else step_req=1 -> STEP.
- RUN:
  - PC_Enable=1 for every cycle spent in RUN.
  - run_req=0 -> HALT; PC_Enable is 0 on the next cycle.
  - step_req is ignored in RUN.
- STEP:
  - PC_Enable=1 for exactly one cycle, then HALT regardless of step_req or run_req.
  - Back-to-back step pulses therefore yield at most one enable per two cycles.
- load_start:
  - In HALT, RUN, STEP, DONE, or IDLE: aborts any execution. PC_Enable=0 from the next cycle, loaded=0, enter LOAD (or FILL if len==0).
  - In LOAD or FILL: ignored; the load in progress completes.
- RAM_Write_Enable is only ever high in the cycle after a LOAD transfer or during FILL. It never overlaps PC_Enable=1.
- Reset mid-load: the load is abandoned. Rows already written stay in RAM, and loaded=0.
- The address counter wraps never; its maximum is DEPTH-1.

Decomposition:
- Shared package (cpu_pkg) holds:
  - FSM state encoding constants (IDLE..STEP).
  - Default DATA_W=11 and ADDR_W=3, shared with CPU/RAM.
  - FILL_WORD default.
- One natural sub-module: exec_gate. It implements the HALT/RUN/STEP sub-FSM that drives PC_Enable, with a load_abort input.
- The load/fill datapath stays in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> all outputs 0, state=0. Release -> remains IDLE.
- Full load: load_start with load_len=8, stream 8 words 11'h101..11'h108 with in_valid held high -> 8 writes to addresses 0..7, one per cycle, each 1 cycle after its transfer. cpu_clear pulses once, loaded=1, state=HALT, no FILL writes.
- Partial load with backpressure: load_len=3, in_valid toggling 1,0,1,0,1 -> addresses 0..2 get the data, then addresses 3..7 get 11'h000 on consecutive cycles, then DONE. Also check load_len=12 saturates to 8.
- Run/step: after load, step_req pulse -> PC_Enable high exactly 1 cycle. run_req high for 5 cycles -> PC_Enable high 5 consecutive cycles, then 0 the cycle after run_req falls.
- Abort: in RUN, pulse load_start with load_len=1 -> PC_Enable 0 next cycle, loaded=0, in_ready=1. load_start pulsed again during LOAD is ignored.
- Reset mid-FILL: reset=0 during FILL -> next cycle IDLE, RAM_Write_Enable=0, loaded=0.
